load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one RV32I data access at a time against a word-indexed memory
// with a combinational read port and a registered, read-modify-write store path.
module load_store_unit #(
    parameter int MEM_ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  mem_write_enable,
    output logic [MEM_ADDR_W-1:0] mem_read_reg,
    input  logic [31:0]           mem_read_data,
    output logic [MEM_ADDR_W-1:0] mem_write_reg,
    output logic [31:0]           mem_write_data
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] RESP  = 3'd3;
    localparam logic [2:0] FAULT = 3'd4;

    logic [2:0]            state_q,  state_d;
    logic                  write_q,  write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [MEM_ADDR_W-1:0] widx_q,   widx_d;
    logic [1:0]            lane_q,   lane_d;
    logic [31:0]           wdata_q,  wdata_d;
    logic [31:0]           merge_q,  merge_d;
    logic [31:0]           rdata_q,  rdata_d;
    logic                  error_q,  error_d;

    logic        legal_op;
    logic        misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic        addr_unused;

    // Address bits above the word index are dropped, so accesses wrap.
    assign addr_unused = ^req_addr[31:MEM_ADDR_W+2];

    assign req_ready        = (state_q == IDLE) && !rst;
    assign resp_valid       = (state_q == RESP) || (state_q == FAULT);
    assign resp_rdata       = rdata_q;
    assign resp_error       = error_q;
    assign mem_write_enable = (state_q == WRITE) && !rst;
    assign mem_read_reg     = widx_q;
    assign mem_write_reg    = widx_q;
    assign mem_write_data   = merge_q;

    always_comb begin
        legal_op = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal_op = 1'b1;
            3'b100, 3'b101:         legal_op = !req_write;
            default:                legal_op = 1'b0;
        endcase
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        ld_byte = mem_read_data[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'h000000, ld_byte};
            3'b101:  load_ext = {16'h0000, ld_half};
            default: load_ext = mem_read_data;
        endcase
    end

    always_comb begin
        merged = mem_read_data;
        case (funct3_q[1:0])
            2'b00:   merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
            2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        widx_d   = widx_q;
        lane_d   = lane_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    widx_d   = req_addr[MEM_ADDR_W+1:2];
                    lane_d   = req_addr[1:0];
                    wdata_d  = req_wdata;
                    if (legal_op && !misaligned) begin
                        state_d = READ;
                    end else begin
                        state_d = FAULT;
                        rdata_d = '0;
                        error_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (write_q) begin
                    merge_d = merged;
                    state_d = WRITE;
                end else begin
                    rdata_d = load_ext;
                    error_d = 1'b0;
                    state_d = RESP;
                end
            end
            WRITE: begin
                rdata_d = '0;
                error_d = 1'b0;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= '0;
            widx_q   <= '0;
            lane_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            widx_q   <= widx_d;
            lane_q   <= lane_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 64-word behavioural memory and
// hand-computed expectations for loads, stores, faults and mid-operation reset.
module tb_load_store_unit;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic          mem_write_enable;
    logic [AW-1:0] mem_read_reg;
    logic [31:0]   mem_read_data;
    logic [AW-1:0] mem_write_reg;
    logic [31:0]   mem_write_data;

    logic [31:0] mem [64];
    logic        mem_init;
    int          wr_count = 0;
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_ADDR_W(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_write_enable (mem_write_enable),
        .mem_read_reg     (mem_read_reg),
        .mem_read_data    (mem_read_data),
        .mem_write_reg    (mem_write_reg),
        .mem_write_data   (mem_write_data)
    );

    assign mem_read_data = mem[mem_read_reg];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
            mem[0] <= 32'h0102_0304;
            mem[3] <= 32'h8899_AABB;
        end else if (mem_write_enable) begin
            mem[mem_write_reg] <= mem_write_data;
        end
    end

    always @(posedge clk) begin
        if (mem_write_enable) wr_count <= wr_count + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the request inputs after acceptance, then wait
    // (bounded) for the response; lat counts cycles from the acceptance cycle.
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output int lat, output int wr_cycle);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        check_val("ready_idle", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = ~w;
        req_funct3 = 3'b111;
        req_addr   = ~a;
        req_wdata  = ~wd;
        lat = 0;
        wr_cycle = -1;
        do begin
            @(negedge clk);
            lat++;
            if (mem_write_enable) wr_cycle = lat;
            check_val("ready_busy", req_ready, 0);
        end while (!resp_valid && lat < 8);
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp);
        int lat, wc, n0;
        n0 = wr_count;
        run_req(1'b0, f3, a, 32'h0, lat, wc);
        check_val({tag, "_lat"}, lat, 2);
        check_val({tag, "_err"}, resp_error, 0);
        check_val({tag, "_data"}, resp_rdata, exp);
        check_val({tag, "_nowr"}, wr_count, n0);
    endtask

    task automatic store_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int idx, input logic [31:0] exp_word);
        int lat, wc, n0;
        n0 = wr_count;
        run_req(1'b1, f3, a, wd, lat, wc);
        check_val({tag, "_lat"}, lat, 3);
        check_val({tag, "_wrcyc"}, wc, 2);
        check_val({tag, "_err"}, resp_error, 0);
        check_val({tag, "_data"}, resp_rdata, 0);
        @(negedge clk);
        check_val({tag, "_wrcnt"}, wr_count, n0 + 1);
        check_val({tag, "_word"}, mem[idx], exp_word);
    endtask

    task automatic fault_chk(input string tag, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input int idx, input logic [31:0] exp_word);
        int lat, wc, n0;
        n0 = wr_count;
        run_req(w, f3, a, 32'hCAFE_F00D, lat, wc);
        check_val({tag, "_lat"}, lat, 1);
        check_val({tag, "_err"}, resp_error, 1);
        check_val({tag, "_wrcyc"}, wc, -1);
        @(negedge clk);
        check_val({tag, "_wrcnt"}, wr_count, n0);
        check_val({tag, "_word"}, mem[idx], exp_word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n0;
        rst        = 1'b1;
        mem_init   = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", req_ready, 0);
        check_val("rst_we", mem_write_enable, 0);
        mem_init = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_valid", resp_valid, 0);
        check_val("rst_rdata", resp_rdata, 0);
        check_val("rst_error", resp_error, 0);
        check_val("rst_ready_out", req_ready, 1);

        load_chk("lb_0d", 3'b000, 32'h0000_000D, 32'hFFFF_FFAA);
        @(negedge clk);
        check_val("hold_rdata", resp_rdata, 32'hFFFF_FFAA);
        check_val("hold_valid", resp_valid, 0);
        load_chk("lbu_0d", 3'b100, 32'h0000_000D, 32'h0000_00AA);
        load_chk("lb_0f", 3'b000, 32'h0000_000F, 32'hFFFF_FF88);
        load_chk("lbu_0c", 3'b100, 32'h0000_000C, 32'h0000_00BB);
        load_chk("lh_0e", 3'b001, 32'h0000_000E, 32'hFFFF_8899);
        load_chk("lhu_0c", 3'b101, 32'h0000_000C, 32'h0000_AABB);
        load_chk("lw_0c", 3'b010, 32'h0000_000C, 32'h8899_AABB);

        store_chk("sh_0e", 3'b001, 32'h0000_000E, 32'h1234_1234, 3, 32'h1234_AABB);
        store_chk("sb_09", 3'b000, 32'h0000_0009, 32'hFFFF_FF5A, 2, 32'h1000_5A02);

        fault_chk("lw_06", 1'b0, 3'b010, 32'h0000_0006, 1, 32'h1000_0001);
        fault_chk("sh_03", 1'b1, 3'b001, 32'h0000_0003, 0, 32'h0102_0304);
        fault_chk("ld_f011", 1'b0, 3'b011, 32'h0000_0004, 1, 32'h1000_0001);
        fault_chk("st_f100", 1'b1, 3'b100, 32'h0000_0004, 1, 32'h1000_0001);

        // SB aborted by reset while in WRITE
        n0 = wr_count;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0010;
        req_wdata  = 32'h0000_0055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_inwrite", mem_write_enable, 1);
        rst = 1'b1;
        #1;
        check_val("abort_we", mem_write_enable, 0);
        check_val("abort_ready", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("abort_ready_out", req_ready, 1);
        check_val("abort_valid", resp_valid, 0);
        check_val("abort_error", resp_error, 0);
        check_val("abort_rdata", resp_rdata, 0);
        @(negedge clk);
        check_val("abort_valid2", resp_valid, 0);
        check_val("abort_wrcnt", wr_count, n0);
        check_val("abort_word", mem[4], 32'h1000_0004);

        store_chk("sw_3c", 3'b010, 32'h0000_003C, 32'hDEAD_BEEF, 15, 32'hDEAD_BEEF);
        load_chk("lw_3c", 3'b010, 32'h0000_003C, 32'hDEAD_BEEF);
        load_chk("lw_100", 3'b010, 32'h0000_0100, 32'h0102_0304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
